// File: rtl/cmd_frame_dec_if.sv
// Command frame decoder bus: demodulator bit stream in,
// decoded command strobe out.
interface cmd_frame_dec_if #(
  parameter int CntW = 5
);
  logic            i_data_dem;
  logic            i_valid_dem;
  logic            i_newcmd_dem;
  logic            i_preamble_dem;
  logic            i_t1_start_dem;
  logic            o_cmd_valid;
  logic [2:0]      o_cmd_type;
  logic [15:0]     o_payload;
  logic            o_crc_err;
  logic [CntW-1:0] o_bit_cnt;

  modport master (
    output i_data_dem,
    output i_valid_dem,
    output i_newcmd_dem,
    output i_preamble_dem,
    output i_t1_start_dem,
    input  o_cmd_valid,
    input  o_cmd_type,
    input  o_payload,
    input  o_crc_err,
    input  o_bit_cnt
  );

  modport slave (
    input  i_data_dem,
    input  i_valid_dem,
    input  i_newcmd_dem,
    input  i_preamble_dem,
    input  i_t1_start_dem,
    output o_cmd_valid,
    output o_cmd_type,
    output o_payload,
    output o_crc_err,
    output o_bit_cnt
  );
endinterface

// File: rtl/cmd_frame_dec.sv
// Reader command frame decoder: collects PIE bits, classifies
// the command by opcode and length, checks Query CRC-5.
module cmd_frame_dec #(
  parameter int         MaxBits    = 22,
  parameter int         CntW       = 5,
  parameter logic [4:0] Crc5Preset = 5'b01001
) (
  input  logic              clk,
  input  logic              rst,
  cmd_frame_dec_if.slave    bus
);
  localparam logic [4:0] Crc5Poly = 5'b01001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [MaxBits-1:0]   r_sr;
  logic [CntW-1:0]      r_cnt;
  logic [4:0]           r_crc;
  logic                 r_ovf;
  logic                 r_cmd_valid;
  logic [2:0]           r_cmd_type;
  logic [15:0]          r_payload;
  logic                 r_crc_err;

  logic                 w_init;
  logic                 w_shift;
  logic                 w_fb;
  logic [4:0]           w_crc_nxt;
  logic [2:0]           w_type;
  logic [15:0]          w_payload;
  logic                 w_crc_err;

  assign bus.o_cmd_valid = r_cmd_valid;
  assign bus.o_cmd_type  = r_cmd_type;
  assign bus.o_payload   = r_payload;
  assign bus.o_crc_err   = r_crc_err;
  assign bus.o_bit_cnt   = r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state; a new frame pulse always wins over end-of-frame
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.i_newcmd_dem) w_next = S_RECV;
      S_RECV: begin
        if (bus.i_newcmd_dem)        w_next = S_RECV;
        else if (bus.i_t1_start_dem) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame init / bit shift controls and CRC-5 step
  always_comb begin
    w_init    = bus.i_newcmd_dem &&
                (r_state == S_IDLE || r_state == S_RECV);
    w_shift   = (r_state == S_RECV) && bus.i_valid_dem &&
                !bus.i_newcmd_dem;
    w_fb      = bus.i_data_dem ^ r_crc[4];
    w_crc_nxt = {r_crc[3:0], 1'b0} ^ (w_fb ? Crc5Poly : 5'b0);
  end

  // Classify the completed frame by length and opcode
  always_comb begin
    w_type    = 3'd7;
    w_payload = 16'h0;
    w_crc_err = 1'b0;
    if (!r_ovf) begin
      unique case (1'b1)
        (r_cnt == CntW'(4) && r_sr[3:2] == 2'b00): begin
          w_type    = 3'd1;
          w_payload = {14'h0, r_sr[1:0]};
        end
        (r_cnt == CntW'(18) && r_sr[17:16] == 2'b01): begin
          w_type    = 3'd2;
          w_payload = r_sr[15:0];
        end
        (r_cnt == CntW'(22) && r_sr[21:18] == 4'b1000 &&
         bus.i_preamble_dem): begin
          w_type    = 3'd3;
          w_payload = {3'h0, r_sr[17:5]};
          w_crc_err = (r_crc != 5'h0);
        end
        (r_cnt == CntW'(9) && r_sr[8:5] == 4'b1001): begin
          w_type    = 3'd4;
          w_payload = {11'h0, r_sr[4:0]};
        end
        (r_cnt == CntW'(8) && r_sr[7:0] == 8'hC0): begin
          w_type    = 3'd5;
        end
        default: begin
          w_type    = 3'd7;
        end
      endcase
    end
  end

  // Frame datapath: shift register, bit counter, CRC, overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_crc <= Crc5Preset;
      r_ovf <= 1'b0;
    end else if (w_init) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_crc <= Crc5Preset;
      r_ovf <= 1'b0;
    end else if (w_shift) begin
      r_sr  <= {r_sr[MaxBits-2:0], bus.i_data_dem};
      r_crc <= w_crc_nxt;
      if (r_cnt < CntW'(MaxBits)) r_cnt <= r_cnt + CntW'(1);
      else                        r_ovf <= 1'b1;
    end
  end

  // Command strobe and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= 3'd0;
      r_payload   <= 16'h0;
      r_crc_err   <= 1'b0;
    end else begin
      r_cmd_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_cmd_type <= w_type;
        r_payload  <= w_payload;
        r_crc_err  <= w_crc_err;
      end
    end
  end
endmodule

// File: tb/tb_cmd_frame_dec.sv
// Bench for cmd_frame_dec: random and directed frames against
// a length/opcode reference model with a strobe scoreboard.
module tb_cmd_frame_dec;
  typedef bit bq_t[$];
  typedef struct {
    logic [2:0]  t;
    logic [15:0] p;
    logic        e;
    logic [4:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [2:0] last_t = 3'd0;

  cmd_frame_dec_if #(.CntW(5)) bus ();

  cmd_frame_dec #(
    .MaxBits(22),
    .CntW(5),
    .Crc5Preset(5'b01001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // CRC-5 by polynomial division modulo x^5+x^3+1
  function automatic logic [4:0] polymod(input longint v);
    longint x = v;
    for (int i = 63; i >= 5; i--)
      if (x[i]) x = x ^ (longint'(6'b101001) << (i - 5));
    return x[4:0];
  endfunction

  function automatic bq_t mk(input longint v, input int n);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  function automatic longint qry(input logic [12:0] prm);
    longint m = (longint'(8) << 13) | longint'(prm);
    logic [4:0] c = polymod((m << 5) ^ (longint'(9) << 17));
    return (m << 5) | longint'(c);
  endfunction

  function automatic exp_t model(input bq_t q, input bit pre);
    exp_t   r;
    int     n = q.size();
    longint v = 0;
    foreach (q[i]) v = (v << 1) | longint'(q[i]);
    r.t = 3'd7;
    r.p = 16'h0;
    r.e = 1'b0;
    r.c = 5'(n > 22 ? 22 : n);
    if (n <= 22) begin
      if (n == 4 && (v >> 2) == 0) begin
        r.t = 3'd1; r.p = 16'(v & 3);
      end else if (n == 18 && (v >> 16) == 1) begin
        r.t = 3'd2; r.p = 16'(v & 'hFFFF);
      end else if (n == 22 && (v >> 18) == 8 && pre) begin
        r.t = 3'd3; r.p = 16'((v >> 5) & 'h1FFF);
        r.e = (polymod((v << 5) ^ (longint'(9) << 22)) != 0);
      end else if (n == 9 && (v >> 5) == 9) begin
        r.t = 3'd4; r.p = 16'(v & 'h1F);
      end else if (n == 8 && v == 'hC0) begin
        r.t = 3'd5;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.i_newcmd_dem = 1'b1;
    step();
    bus.i_newcmd_dem = 1'b0;
  endtask

  task automatic send_bits(input bq_t q, input bit t1, input bit same);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(0, 2)) step();
      bus.i_data_dem  = q[i];
      bus.i_valid_dem = 1'b1;
      if (t1 && same && i == q.size() - 1) bus.i_t1_start_dem = 1'b1;
      step();
      bus.i_valid_dem    = 1'b0;
      bus.i_t1_start_dem = 1'b0;
      bus.i_data_dem     = 1'b0;
    end
    if (t1 && !(same && q.size() > 0)) begin
      repeat ($urandom_range(0, 2)) step();
      bus.i_t1_start_dem = 1'b1;
      step();
      bus.i_t1_start_dem = 1'b0;
    end
  endtask

  task automatic frame(input bq_t q, input bit pre, input bit same);
    exp_t e = model(q, pre);
    bus.i_preamble_dem = pre;
    sb.push_back(e);
    last_t = e.t;
    start();
    send_bits(q, 1'b1, same);
    repeat (4) step();
    chk("type_hold", {29'h0, bus.o_cmd_type}, {29'h0, last_t});
  endtask

  // Monitor: every strobe must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_cmd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("cmd_type", {29'h0, bus.o_cmd_type}, {29'h0, e.t});
          chk("payload", {16'h0, bus.o_payload}, {16'h0, e.p});
          chk("crc_err", {31'h0, bus.o_crc_err}, {31'h0, e.e});
          chk("bit_cnt", {27'h0, bus.o_bit_cnt}, {27'h0, e.c});
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {31'h0, bus.o_cmd_valid}, 32'h0);
    chk({nm, "_type"}, {29'h0, bus.o_cmd_type}, 32'h0);
    chk({nm, "_payload"}, {16'h0, bus.o_payload}, 32'h0);
    chk({nm, "_crc_err"}, {31'h0, bus.o_crc_err}, 32'h0);
    chk({nm, "_bit_cnt"}, {27'h0, bus.o_bit_cnt}, 32'h0);
  endtask

  initial begin
    longint v;
    int     k;
    int     w;
    bq_t    q;
    bus.i_data_dem     = 1'b0;
    bus.i_valid_dem    = 1'b0;
    bus.i_newcmd_dem   = 1'b0;
    bus.i_preamble_dem = 1'b0;
    bus.i_t1_start_dem = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    frame(mk(4'b0010, 4), 1'b0, 1'b0);
    frame(mk((longint'(1) << 16) | 'hA5C3, 18), 1'b0, 1'b0);
    v = qry(13'h0A5F);
    frame(mk(v, 22), 1'b1, 1'b0);
    frame(mk(v ^ 'h4, 22), 1'b1, 1'b1);
    frame(mk(v, 22), 1'b0, 1'b0);
    q = {};
    for (int i = 0; i < 23; i++) q.push_back(bit'($urandom_range(0, 1)));
    frame(q, 1'b1, 1'b0);

    bus.i_preamble_dem = 1'b0;
    start();
    send_bits(mk('h2D, 6), 1'b0, 1'b0);
    frame(mk('hC0, 8), 1'b0, 1'b0);
    frame(mk(9'b1001_00_011, 9), 1'b0, 1'b1);

    bus.i_preamble_dem = 1'b1;
    start();
    send_bits(mk(v >> 12, 10), 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_zero("midreset");
    rst = 1'b0;
    last_t = 3'd0;
    step();
    frame(mk(4'b0011, 4), 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_valid_dem    = 1'b1;
        bus.i_t1_start_dem = 1'b1;
        step();
        bus.i_valid_dem    = 1'b0;
        bus.i_t1_start_dem = 1'b0;
      end
      k = $urandom_range(0, 7);
      case (k)
        0: q = mk(longint'($urandom_range(0, 3)), 4);
        1: q = mk((longint'(1) << 16) | longint'($urandom & 'hFFFF), 18);
        2: q = mk(qry(13'($urandom)), 22);
        3: q = mk(qry(13'($urandom)) ^
                  (longint'(1) << $urandom_range(0, 4)), 22);
        4: q = mk((longint'(9) << 5) | longint'($urandom_range(0, 31)), 9);
        5: q = mk('hC0, 8);
        6: begin
          q = {};
          w = $urandom_range(0, 25);
          for (int i = 0; i < w; i++)
            q.push_back(bit'($urandom_range(0, 1)));
        end
        default: q = mk(qry(13'($urandom)), 22);
      endcase
      frame(q, (k == 7) ? 1'b0 : bit'($urandom_range(0, 1)) | (k != 6),
            bit'($urandom_range(0, 1)));
    end

    w = 0;
    while (sb.size() > 0 && w < 50) begin
      step();
      w++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmd_frame_dec.md
Name: cmd_frame_dec

Overview:
Downstream stage of the PIE demodulator. Collects demodulated bits of one reader command into a shift register. At end of frame, classifies the command by opcode and exact bit length, and checks CRC-5 for Query. Emits a one-cycle command strobe with type and right-aligned payload to the tag control FSM.

Parameters:
MaxBits, 22, shift-register depth and bit-count saturation limit (longest supported command, Query)
CntW, 5, bit-counter width
Crc5Preset, 5'b01001, CRC-5 preset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_data_dem  in  1  demodulated bit value, sampled when i_valid_dem=1
i_valid_dem  in  1  one-cycle bit strobe from demodulator
i_newcmd_dem  in  1  one-cycle pulse: RTcal accepted, new frame starting
i_preamble_dem  in  1  level: 1 = current frame began with full preamble (TRcal seen)
i_t1_start_dem  in  1  one-cycle end-of-frame strobe from demodulator
o_cmd_valid  out  1  one-cycle command strobe
o_cmd_type  out  3  0 none, 1 QueryRep, 2 ACK, 3 Query, 4 QueryAdjust, 5 NAK, 7 invalid
o_payload  out  16  command fields after opcode, MSB-first, right-aligned, zero-filled
o_crc_err  out  1  valid with o_cmd_valid; 1 = Query CRC-5 residue nonzero
o_bit_cnt  out  CntW  bits received in current/last frame (debug)

Behaviour:
- Reset values: o_cmd_valid=0, o_cmd_type=0, o_payload=0, o_crc_err=0, o_bit_cnt=0, state=IDLE, shift register=0, crc=Crc5Preset, overflow flag=0. Reset mid-frame discards the frame; no strobe is produced.
- States: IDLE, RECV, DONE.
- IDLE -> RECV on i_newcmd_dem. In this cycle: bit_cnt=0, sr=0, crc=Crc5Preset, ovf=0.
- RECV:
  - Each i_valid_dem: sr={sr[MaxBits-2:0],i_data_dem}.
  - If bit_cnt<MaxBits, bit_cnt+=1; else ovf=1 and bit_cnt holds at MaxBits.
  - CRC update per bit: fb=i_data_dem^crc[4]; crc={crc[3:0],1'b0}^(fb?5'b01001:5'b0).
  - i_t1_start_dem -> DONE. If i_valid_dem and i_t1_start_dem occur in the same cycle, the bit is shifted in first.
  - i_newcmd_dem in RECV restarts the frame (same init as from IDLE), stays in RECV, and produces no strobe.
- DONE: lasts one cycle and always returns to IDLE.
  - Registers o_cmd_valid=1 and o_cmd_type, o_payload, o_crc_err. Outputs are visible the cycle after DONE is entered, i.e. 2 clocks after the i_t1_start_dem edge.
  - o_cmd_valid is otherwise 0.
  - o_payload and o_cmd_type hold until the next strobe.
- Classification, first bit received = MSB. Length n=bit_cnt. ovf=1 forces type 7.
  - n=4, sr[3:2]=00 -> QueryRep; payload[1:0]=session.
  - n=18, sr[17:16]=01 -> ACK; payload[15:0]=RN16.
  - n=22, sr[21:18]=1000, i_preamble_dem=1 -> Query; payload[12:0]=sr[17:5]; o_crc_err=(crc!=0).
  - n=9, sr[8:5]=1001 -> QueryAdjust; payload[4:0]=sr[4:0].
  - n=8, sr[7:0]=8'hC0 -> NAK; payload=0.
  - Anything else -> type 7, payload=0.
  - A Query opcode with i_preamble_dem=0 -> type 7.
- o_crc_err is 0 for every type except Query.
- i_t1_start_dem or i_valid_dem while in IDLE is ignored.

Test Plan:
1. Reset, then newcmd and bits 0,0,1,0, then t1_start -> o_cmd_valid pulse, type=1, payload=16'h0002, crc_err=0.
2. Frame-sync frame with ACK 01 followed by RN16 16'hA5C3 -> type=2, payload=16'hA5C3, o_bit_cnt=18.
3. Preamble=1, Query 1000 + params 13'h0A5F + correct CRC-5 -> type=3, payload=16'h0A5F, crc_err=0. Same frame with one CRC bit flipped -> type=3, crc_err=1.
4. Query opcode, 22 bits, preamble=0 -> type=7. 23 bits of any content -> type=7, o_bit_cnt=22.
5. newcmd after 6 bits, then NAK 8'hC0 and t1_start -> exactly one strobe, type=5. Bit and t1_start in the same cycle completing QueryAdjust 1001_00_011 -> type=4, payload=5'b00011.
6. Assert rst after 10 bits of a Query -> no strobe, all outputs 0. A following clean QueryRep decodes normally.
